vs_sci_reader: RTL and testbench
================================

Name: vs_sci_reader

Overview:
- SPI master that reads registers over the VS1003 SCI (serial control interface). It is the read-direction counterpart to the existing SCI/SDI write path.
- For each request it issues the READ opcode 8'h03 and an 8-bit register address on SI, then shifts 16 bits in from SO, MSB first.
- Used by the player top to poll SCI_DECODE_TIME, SCI_HDAT0/1, SCI_STATUS and SCI_VOL, to drive the display and to verify volume writes.
- The top muxes XCS/SCLK/SI between the writer and this block using busy: this block owns the SCI lines while busy=1.

Parameters:
- HALF_DIV, 50, CLK cycles per SCLK half-period (100 MHz CLK gives 1 MHz SCLK); minimum 2.
- GAP_CYC, 8, CLK cycles XCS stays high after a transaction before the next request is accepted.
- DREQ_TIMEOUT, 100000, CLK cycles to wait for DREQ high before aborting.

Ports:
- CLK  in  1  system clock.
- init  in  1  reset; asynchronous, active-low.
- req  in  1  read request; sampled only in IDLE.
- addr  in  8  SCI register address; captured when req is accepted.
- DREQ  in  1  VS1003 data request / ready.
- SO  in  1  VS1003 serial data out.
- XCS  out  1  SCI chip select, active-low.
- SCLK  out  1  SPI clock, idle low.
- SI  out  1  serial data to VS1003.
- rdata  out  16  last register value read.
- rvalid  out  1  one-cycle pulse when rdata updates.
- err  out  1  one-cycle pulse on DREQ timeout.
- busy  out  1  high from request acceptance through the end of GAP.

Behaviour:
- Reset (init=0, takes effect immediately): XCS=1, SCLK=0, SI=0, rdata=16'h0000, rvalid=0, err=0, busy=0, state=IDLE, all counters=0.
- Reset mid-transaction aborts it. No partial rdata is written and no rvalid is produced.
- States: IDLE, WAIT_DREQ, SHIFT, HOLD, GAP.
- IDLE:
  - When req=1, capture the shift register as {8'h03, addr} and go to WAIT_DREQ.
  - busy=1 from the next cycle.
  - req while busy=1 is ignored and is not queued.
- WAIT_DREQ:
  - If DREQ=1, drive XCS=0 and SI=bit31 (0), clear bitcnt, go to SHIFT.
  - Otherwise count; when the count reaches DREQ_TIMEOUT, pulse err for 1 cycle, leave rdata unchanged, go to GAP.
  - XCS stays high throughout the timeout path.
- SHIFT (32 bits, bit period = 2*HALF_DIV CLK cycles):
  - SCLK low for HALF_DIV cycles, then high for HALF_DIV cycles.
  - On the rising edge of SCLK, if bitcnt>=16, shift SO into the LSB of the capture register.
  - On the falling edge, increment bitcnt and present the next SI bit.
  - SI is driven for bits 0..15 (opcode, then address). For bits 16..31 SI=0.
  - After the falling edge of bit 31, go to HOLD with SCLK=0.
  - DREQ is ignored once SHIFT has started.
- HOLD:
  - Wait HALF_DIV cycles with XCS=0 and SCLK=0, then set XCS=1.
  - Load rdata from the capture register and pulse rvalid in the same cycle, then go to GAP.
- GAP: keep XCS=1 for GAP_CYC cycles, then go to IDLE and drop busy.
- Data is MSB first in both directions.
- A full read takes exactly 32*2*HALF_DIV + HALF_DIV CLK cycles from XCS falling to XCS rising.
- SCLK never glitches and never runs while XCS=1.

Decomposition:
- Shared package vs_pkg holds:
  - SCI opcodes: SCI_READ=8'h03, SCI_WRITE=8'h02.
  - Register addresses: MODE 0, STATUS 1, CLOCKF 3, DECODE_TIME 4, HDAT0 8, HDAT1 9, VOL 0B.
  - The state enum.
- One sub-module, spi_clk_gen:
  - HALF_DIV counter with an enable input.
  - Outputs SCLK, a rise strobe and a fall strobe.
  - The writer path can reuse it.

Test Plan:
- Basic read: HALF_DIV=4, DREQ=1, slave model returns 16'hA5C3 for addr 8'h0B; pulse req with addr=8'h0B -> SI carries 32'h030B0000 MSB first, rdata=16'hA5C3, one rvalid pulse, XCS low for exactly 260 CLK cycles.
- DREQ stall: hold DREQ=0 for 500 cycles after req -> XCS stays 1 and SCLK stays 0 throughout; the transaction starts the cycle after DREQ rises and returns the correct value.
- Timeout: DREQ_TIMEOUT=50, DREQ stuck at 0 -> err pulses once at cycle 50, XCS never falls, rdata unchanged, busy clears after GAP_CYC.
- Back-to-back: req held high continuously, addr 8'h04 then 8'h08 -> two transactions separated by at least GAP_CYC cycles of XCS=1; req during busy is not double-counted.
- Reset mid-shift: assert init=0 at bit 20 -> XCS=1, SCLK=0 and busy=0 immediately; no rvalid; the next read after release returns the correct value.
- Edge cases: slave returns 16'h0000 and 16'hFFFF -> rdata matches exactly; verifies the rising-edge sampling alignment.

Source files
------------

// File: rtl/vs_pkg.sv
// Shared VS1003 definitions: SCI opcodes, register map and the SCI reader state encoding.
package vs_pkg;

    localparam logic [7:0] SCI_READ  = 8'h03;
    localparam logic [7:0] SCI_WRITE = 8'h02;

    localparam logic [7:0] SCI_MODE        = 8'h00;
    localparam logic [7:0] SCI_STATUS      = 8'h01;
    localparam logic [7:0] SCI_CLOCKF      = 8'h03;
    localparam logic [7:0] SCI_DECODE_TIME = 8'h04;
    localparam logic [7:0] SCI_HDAT0       = 8'h08;
    localparam logic [7:0] SCI_HDAT1       = 8'h09;
    localparam logic [7:0] SCI_VOL         = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DREQ,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } sci_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock divider: SCLK idles low while disabled; rise/fall strobe on the CLK edge where SCLK toggles.
module spi_clk_gen #(
    parameter int HALF_DIV = 50
) (
    input  logic CLK,
    input  logic init,
    input  logic en,
    output logic SCLK,
    output logic rise,
    output logic fall
);

    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_reg;
    logic             sclk_reg;
    logic             edge_due;

    assign edge_due = en && (div_cnt_reg == DIV_W'(HALF_DIV - 1));
    assign rise     = edge_due && !sclk_reg;
    assign fall     = edge_due && sclk_reg;
    assign SCLK     = sclk_reg;

    always_ff @(posedge CLK or negedge init) begin
        if (!init) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
        end else if (!en) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
        end else if (edge_due) begin
            div_cnt_reg <= '0;
            sclk_reg    <= !sclk_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/vs_sci_reader.sv
// VS1003 SCI register reader: sends READ opcode + address on SI, then clocks 16 data bits in from SO.
module vs_sci_reader
    import vs_pkg::*;
#(
    parameter int HALF_DIV     = 50,
    parameter int GAP_CYC      = 8,
    parameter int DREQ_TIMEOUT = 100000
) (
    input  logic        CLK,
    input  logic        init,
    input  logic        req,
    input  logic [7:0]  addr,
    input  logic        DREQ,
    input  logic        SO,
    output logic        XCS,
    output logic        SCLK,
    output logic        SI,
    output logic [15:0] rdata,
    output logic        rvalid,
    output logic        err,
    output logic        busy
);

    localparam int CNT_W = $clog2(max3(DREQ_TIMEOUT, GAP_CYC, HALF_DIV) + 1);

    sci_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [4:0]       bitcnt_reg, bitcnt_next;
    logic [31:0]      shift_reg, shift_next;
    logic [15:0]      cap_reg, cap_next;
    logic [15:0]      rdata_reg, rdata_next;
    logic             xcs_reg, xcs_next;
    logic             si_reg, si_next;
    logic             rvalid_reg, rvalid_next;
    logic             err_reg, err_next;
    logic             sclk_rise, sclk_fall;

    spi_clk_gen #(
        .HALF_DIV(HALF_DIV)
    ) u_clk_gen (
        .CLK (CLK),
        .init(init),
        .en  (state_reg == ST_SHIFT),
        .SCLK(SCLK),
        .rise(sclk_rise),
        .fall(sclk_fall)
    );

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        bitcnt_next = bitcnt_reg;
        shift_next  = shift_reg;
        cap_next    = cap_reg;
        rdata_next  = rdata_reg;
        xcs_next    = xcs_reg;
        si_next     = si_reg;
        rvalid_next = 1'b0;
        err_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    shift_next = {SCI_READ, addr, 16'h0000};
                    cnt_next   = '0;
                    state_next = ST_WAIT_DREQ;
                end
            end
            ST_WAIT_DREQ: begin
                if (DREQ) begin
                    xcs_next    = 1'b0;
                    si_next     = shift_reg[31];
                    bitcnt_next = '0;
                    state_next  = ST_SHIFT;
                end else if (cnt_reg == CNT_W'(DREQ_TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_GAP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_SHIFT: begin
                // Bits 16..31 are the data phase; the lower half of shift_reg feeds zeros onto SI there.
                if (sclk_rise && bitcnt_reg[4]) begin
                    cap_next = {cap_reg[14:0], SO};
                end
                if (sclk_fall) begin
                    if (bitcnt_reg == 5'd31) begin
                        si_next    = 1'b0;
                        cnt_next   = '0;
                        state_next = ST_HOLD;
                    end else begin
                        bitcnt_next = bitcnt_reg + 5'd1;
                        shift_next  = {shift_reg[30:0], 1'b0};
                        si_next     = shift_reg[30];
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_reg == CNT_W'(HALF_DIV - 1)) begin
                    xcs_next    = 1'b1;
                    rdata_next  = cap_reg;
                    rvalid_next = 1'b1;
                    cnt_next    = '0;
                    state_next  = ST_GAP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_reg == CNT_W'(GAP_CYC - 1)) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge init) begin
        if (!init) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            bitcnt_reg <= '0;
            shift_reg  <= '0;
            cap_reg    <= '0;
            rdata_reg  <= '0;
            xcs_reg    <= 1'b1;
            si_reg     <= 1'b0;
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bitcnt_reg <= bitcnt_next;
            shift_reg  <= shift_next;
            cap_reg    <= cap_next;
            rdata_reg  <= rdata_next;
            xcs_reg    <= xcs_next;
            si_reg     <= si_next;
            rvalid_reg <= rvalid_next;
            err_reg    <= err_next;
        end
    end

    assign XCS    = xcs_reg;
    assign SI     = si_reg;
    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;
    assign err    = err_reg;
    assign busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_vs_sci_reader.sv
// Bench for vs_sci_reader: behavioural VS1003 slave with a register array, vector table, random reads and corner sequences.
module tb_vs_sci_reader;

    localparam int HALF_DIV  = 4;
    localparam int GAP_CYC   = 8;
    localparam int TO_MAIN   = 1000;
    localparam int TO_SHORT  = 50;
    localparam int EXP_LOW   = 32 * 2 * HALF_DIV + HALF_DIV;

    logic        CLK = 1'b0;
    logic        init = 1'b0;
    logic        req = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic        DREQ = 1'b1;
    logic        SO = 1'b0;
    logic        XCS, SCLK, SI, rvalid, err, busy;
    logic [15:0] rdata;

    logic        req_t = 1'b0;
    logic [7:0]  addr_t = 8'h00;
    logic        DREQ_t = 1'b0;
    logic        SO_t = 1'b0;
    logic        XCS_t, SCLK_t, SI_t, rvalid_t, err_t, busy_t;
    logic [15:0] rdata_t;

    always #5 CLK = ~CLK;

    vs_sci_reader #(.HALF_DIV(HALF_DIV), .GAP_CYC(GAP_CYC), .DREQ_TIMEOUT(TO_MAIN)) dut (
        .CLK(CLK), .init(init), .req(req), .addr(addr), .DREQ(DREQ), .SO(SO),
        .XCS(XCS), .SCLK(SCLK), .SI(SI), .rdata(rdata), .rvalid(rvalid), .err(err), .busy(busy)
    );

    vs_sci_reader #(.HALF_DIV(HALF_DIV), .GAP_CYC(GAP_CYC), .DREQ_TIMEOUT(TO_SHORT)) dut_t (
        .CLK(CLK), .init(init), .req(req_t), .addr(addr_t), .DREQ(DREQ_t), .SO(SO_t),
        .XCS(XCS_t), .SCLK(SCLK_t), .SI(SI_t), .rdata(rdata_t), .rvalid(rvalid_t), .err(err_t), .busy(busy_t)
    );

    // Slave model: samples SI on SCLK rise, changes SO after SCLK fall, register contents from regs[].
    logic [15:0] regs [256];
    logic [31:0] slave_mosi = 32'h0;
    logic [15:0] slave_word = 16'h0;
    int          slave_rcnt = 0;

    always @(negedge XCS) slave_rcnt = 0;
    always @(posedge SCLK) begin
        slave_mosi = {slave_mosi[30:0], SI};
        slave_rcnt = slave_rcnt + 1;
    end
    always @(negedge SCLK) begin
        if (slave_rcnt == 16) slave_word = regs[slave_mosi[7:0]];
        if (slave_rcnt >= 16 && slave_rcnt < 32) SO = slave_word[31 - slave_rcnt];
    end

    int rvalid_total = 0;
    int sclk_bad = 0;
    always @(negedge CLK) begin
        if (rvalid === 1'b1) rvalid_total = rvalid_total + 1;
        if (XCS === 1'b1 && SCLK === 1'b1) sclk_bad = sclk_bad + 1;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        check({tag, "_idle_wait"}, {31'h0, busy}, 32'h0);
        #1;
    endtask

    task automatic do_read(input string tag, input logic [7:0] a, input int delay,
                           input logic [15:0] exp_data, input int exp_low);
        int low_cnt;
        int stall_bad;
        int rv_before;
        wait_idle(tag);
        rv_before = rvalid_total;
        DREQ = (delay == 0);
        req  = 1'b1;
        addr = a;
        @(negedge CLK);
        req = 1'b0;
        check({tag, "_busy"}, {31'h0, busy}, 32'h1);
        stall_bad = 0;
        for (int i = 0; i < delay; i++) begin
            if (XCS !== 1'b1 || SCLK !== 1'b0) stall_bad++;
            @(negedge CLK);
        end
        if (delay > 0) check({tag, "_stall_lines"}, stall_bad, 0);
        DREQ = 1'b1;
        @(negedge CLK);
        check({tag, "_start"}, {31'h0, XCS}, 32'h0);
        low_cnt = 0;
        while (XCS === 1'b0 && low_cnt < 4000) begin
            low_cnt++;
            @(negedge CLK);
        end
        check({tag, "_xcs_low"}, low_cnt, exp_low);
        check({tag, "_rvalid"}, {31'h0, rvalid}, 32'h1);
        check({tag, "_rdata"}, {16'h0, rdata}, {16'h0, exp_data});
        check({tag, "_si_word"}, slave_mosi, {8'h03, a, 16'h0000});
        $display("read %s addr=%h delay=%0d rdata=%h xcs_low=%0d", tag, a, delay, rdata, low_cnt);
        @(negedge CLK);
        check({tag, "_rvalid_pulse"}, {31'h0, rvalid}, 32'h0);
        wait_idle(tag);
        check({tag, "_rvalid_count"}, rvalid_total - rv_before, 1);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] slave_val;
        int          dreq_delay;
        logic [15:0] exp_rdata;
        int          exp_low;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 2 ms");
        $fatal(1, "global timeout");
    end

    initial begin
        int cyc, k, rv_before, xcs_bad, err_cnt;
        int falls, rises, gap, nrv;
        logic prev_xcs, idle_seen, req_dropped;
        logic [15:0] rd0, rd1;
        logic [7:0]  ra;
        logic [15:0] rv;

        for (int i = 0; i < 256; i++) regs[i] = 16'h0000;

        vecs[0] = '{8'h0B, 16'hA5C3, 0,   16'hA5C3, EXP_LOW};
        vecs[1] = '{8'h04, 16'h0000, 0,   16'h0000, EXP_LOW};
        vecs[2] = '{8'h08, 16'hFFFF, 0,   16'hFFFF, EXP_LOW};
        vecs[3] = '{8'h09, 16'h1234, 500, 16'h1234, EXP_LOW};
        vecs[4] = '{8'h01, 16'h8001, 3,   16'h8001, EXP_LOW};
        vecs[5] = '{8'h00, 16'h7FFE, 1,   16'h7FFE, EXP_LOW};

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_xcs",    {31'h0, XCS},    32'h1);
        check("rst_sclk",   {31'h0, SCLK},   32'h0);
        check("rst_si",     {31'h0, SI},     32'h0);
        check("rst_rdata",  {16'h0, rdata},  32'h0);
        check("rst_rvalid", {31'h0, rvalid}, 32'h0);
        check("rst_err",    {31'h0, err},    32'h0);
        check("rst_busy",   {31'h0, busy},   32'h0);
        init = 1'b1;
        @(negedge CLK);

        // Table-driven reads
        foreach (vecs[i]) begin
            regs[vecs[i].addr] = vecs[i].slave_val;
            do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].dreq_delay,
                    vecs[i].exp_rdata, vecs[i].exp_low);
        end

        // Randomised reads against the register-array model
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom_range(0, 255));
            rv = 16'($urandom);
            regs[ra] = rv;
            do_read($sformatf("rnd%0d", i), ra, int'($urandom_range(0, 30)), rv, EXP_LOW);
        end

        // Back-to-back with req held high
        regs[8'h04] = 16'h1A2B;
        regs[8'h08] = 16'hC0DE;
        wait_idle("b2b");
        rv_before = rvalid_total;
        DREQ = 1'b1;
        req  = 1'b1;
        addr = 8'h04;
        falls = 0; rises = 0; gap = 0; nrv = 0;
        prev_xcs = 1'b1; idle_seen = 1'b0; req_dropped = 1'b0;
        rd0 = 16'h0; rd1 = 16'h0;
        for (int i = 0; i < 900; i++) begin
            @(negedge CLK);
            if (busy && !req_dropped && idle_seen) begin
                req = 1'b0;
                req_dropped = 1'b1;
            end
            if (busy && addr == 8'h04) addr = 8'h08;
            if (!busy && rises > 0) idle_seen = 1'b1;
            if (prev_xcs && !XCS) falls++;
            if (!prev_xcs && XCS) rises++;
            if (XCS && rises == 1 && falls == 1) gap++;
            if (rvalid) begin
                if (nrv == 0) rd0 = rdata;
                else rd1 = rdata;
                nrv++;
            end
            prev_xcs = XCS;
        end
        req = 1'b0;
        $display("read b2b first=%h second=%h gap=%0d transactions=%0d", rd0, rd1, gap, falls);
        check("b2b_transactions", falls, 2);
        check("b2b_rvalids", nrv, 2);
        check("b2b_gap_ok", {31'h0, (gap >= GAP_CYC)}, 32'h1);
        check("b2b_rdata0", {16'h0, rd0}, 32'h1A2B);
        check("b2b_rdata1", {16'h0, rd1}, 32'hC0DE);
        check("b2b_si_word", slave_mosi, 32'h03080000);
        #1;
        check("b2b_rvalid_total", rvalid_total - rv_before, 2);

        // Reset in the middle of the data phase
        regs[8'h03] = 16'h5A96;
        wait_idle("rst_mid");
        rv_before = rvalid_total;
        DREQ = 1'b1;
        req  = 1'b1;
        addr = 8'h03;
        @(negedge CLK);
        req = 1'b0;
        cyc = 0;
        while (slave_rcnt < 20 && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
        end
        check("rst_mid_reached_bit20", {31'h0, (slave_rcnt >= 20)}, 32'h1);
        init = 1'b0;
        #1;
        check("rst_mid_xcs",   {31'h0, XCS},   32'h1);
        check("rst_mid_sclk",  {31'h0, SCLK},  32'h0);
        check("rst_mid_busy",  {31'h0, busy},  32'h0);
        check("rst_mid_rdata", {16'h0, rdata}, 32'h0);
        repeat (3) @(negedge CLK);
        init = 1'b1;
        @(negedge CLK);
        #1;
        check("rst_mid_no_rvalid", rvalid_total - rv_before, 0);
        $display("read rst_mid addr=03 aborted at bit %0d", slave_rcnt);
        do_read("after_rst", 8'h03, 0, 16'h5A96, EXP_LOW);

        // DREQ timeout on the short-timeout instance
        @(negedge CLK);
        DREQ_t = 1'b0;
        req_t  = 1'b1;
        addr_t = 8'h01;
        @(negedge CLK);
        req_t = 1'b0;
        cyc = 1; xcs_bad = 0; err_cnt = 0;
        while (err_t !== 1'b1 && cyc < 200) begin
            if (XCS_t !== 1'b1 || SCLK_t !== 1'b0) xcs_bad++;
            @(negedge CLK);
            cyc++;
        end
        // cyc counts negedges from the one before the accepting edge
        check("to_latency", cyc - 1, TO_SHORT);
        check("to_rdata", {16'h0, rdata_t}, 32'h0);
        if (err_t === 1'b1) err_cnt++;
        k = 0;
        while (busy_t !== 1'b0 && k < 100) begin
            @(negedge CLK);
            k++;
            if (err_t === 1'b1) err_cnt++;
            if (XCS_t !== 1'b1 || SCLK_t !== 1'b0) xcs_bad++;
        end
        check("to_busy_clear", k, GAP_CYC);
        check("to_err_pulses", err_cnt, 1);
        check("to_xcs_high", xcs_bad, 0);
        check("to_no_rvalid", {31'h0, rvalid_t}, 32'h0);
        $display("read timeout addr=01 err_after=%0d busy_clear_after=%0d", cyc - 1, k);

        check("sclk_while_xcs_high", sclk_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
